// File: rtl/trace_memory_ctrl.sv
// Trace word RAM behind the tracer: circular history buffer with post-trigger freeze (trace mode) or FIFO (stream mode).
// Loads are granted one cycle after the request; stores are refused when frozen (trace) or full (stream).
module trace_memory_ctrl #(
   parameter int TRB_WIDTH  = 32,
   parameter int TRB_DEPTH  = 64,
   parameter int DELAY_BITS = 16
) (
   input  logic                         FPGA_CLK_I,
   input  logic                         RST_NI,
   input  logic [1:0]                   MODE_I,
   input  logic [DELAY_BITS-1:0]        TRG_DELAY_I,
   input  logic                         TRG_EVENT_I,
   output logic                         TRG_DELAYED_O,
   output logic [$clog2(TRB_DEPTH)-1:0] TRG_ADDR_O,
   input  logic                         STORE_I,
   output logic                         STORE_PERM_O,
   input  logic [TRB_WIDTH-1:0]         DATA_I,
   input  logic                         LOAD_REQUEST_I,
   output logic                         LOAD_GRANT_O,
   output logic [TRB_WIDTH-1:0]         DATA_O
);

   localparam int AW = $clog2(TRB_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(TRB_DEPTH);

   localparam logic [1:0] ST_ARMED    = 2'd0;
   localparam logic [1:0] ST_DELAYING = 2'd1;
   localparam logic [1:0] ST_FROZEN   = 2'd2;

   logic [TRB_WIDTH-1:0]  mem [TRB_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [DELAY_BITS-1:0] dcnt;
   logic [1:0]            state;
   logic [1:0]            mode_q;
   logic                  load_grant;
   logic                  stream_mode;
   logic                  mode_chg;
   logic                  acc;
   logic                  load;

   assign stream_mode = (MODE_I != 2'd0);
   assign mode_chg    = (MODE_I != mode_q);

   // A mode switch cycle accepts nothing, so permission is withheld too.
   always_comb begin
      STORE_PERM_O = 1'b0;
      if (!mode_chg) begin
         if (stream_mode) STORE_PERM_O = (count < FULL_CNT);
         else             STORE_PERM_O = (state != ST_FROZEN);
      end
   end

   assign acc  = STORE_I & STORE_PERM_O;
   // No grant back-to-back: a request still high in its grant cycle is the same request.
   assign load = ~mode_chg & LOAD_REQUEST_I & ~load_grant & (~stream_mode | (count != '0));

   assign LOAD_GRANT_O  = load_grant;
   assign TRG_DELAYED_O = (state == ST_FROZEN);

   always_ff @(posedge FPGA_CLK_I) begin
      if (acc) mem[wr_ptr] <= DATA_I;
   end

   always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dcnt       <= '0;
         state      <= ST_ARMED;
         mode_q     <= 2'd0;
         load_grant <= 1'b0;
         DATA_O     <= '0;
         TRG_ADDR_O <= '0;
      end else begin
         mode_q <= MODE_I;
         if (mode_chg) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dcnt       <= '0;
            state      <= ST_ARMED;
            load_grant <= 1'b0;
            TRG_ADDR_O <= '0;
         end else begin
            load_grant <= load;
            if (acc) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
               // Trace reads the word about to be overwritten, i.e. the oldest one.
               DATA_O <= stream_mode ? mem[rd_ptr] : mem[wr_ptr];
               if (stream_mode) rd_ptr <= rd_ptr + AW'(1);
            end
            if (stream_mode) begin
               state <= ST_ARMED;
               if (acc && !load)      count <= count + (AW+1)'(1);
               else if (!acc && load) count <= count - (AW+1)'(1);
            end else begin
               case (state)
                  ST_ARMED: begin
                     if (TRG_EVENT_I) begin
                        state      <= ST_DELAYING;
                        TRG_ADDR_O <= wr_ptr;
                        dcnt       <= '0;
                     end
                  end
                  ST_DELAYING: begin
                     if (dcnt == TRG_DELAY_I) state <= ST_FROZEN;
                     else if (acc)            dcnt  <= dcnt + DELAY_BITS'(1);
                  end
                  ST_FROZEN: state <= ST_FROZEN;
                  default:   state <= ST_ARMED;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_trace_memory_ctrl.sv
// Bench for trace_memory_ctrl at TRB_DEPTH=4: trace-mode vector table, corner sequences, random stream vs queue model.
module tb_trace_memory_ctrl;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic [15:0] trg_delay = 16'd3;
   logic        trg_event = 1'b0;
   logic        trg_delayed;
   logic [1:0]  trg_addr;
   logic        store = 1'b0;
   logic        store_perm;
   logic [31:0] din = 32'd0;
   logic        load_req = 1'b0;
   logic        load_grant;
   logic [31:0] dout;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   trace_memory_ctrl #(.TRB_WIDTH(32), .TRB_DEPTH(D), .DELAY_BITS(16)) dut (
      .FPGA_CLK_I     (clk),
      .RST_NI         (rst_n),
      .MODE_I         (mode),
      .TRG_DELAY_I    (trg_delay),
      .TRG_EVENT_I    (trg_event),
      .TRG_DELAYED_O  (trg_delayed),
      .TRG_ADDR_O     (trg_addr),
      .STORE_I        (store),
      .STORE_PERM_O   (store_perm),
      .DATA_I         (din),
      .LOAD_REQUEST_I (load_req),
      .LOAD_GRANT_O   (load_grant),
      .DATA_O         (dout)
   );

   typedef struct {
      logic        st;
      logic [31:0] d;
      logic        rq;
      logic        ev;
      logic        exp_perm;
      logic        exp_gnt;
      logic [31:0] exp_dout;
      logic        exp_dly;
      logic [1:0]  exp_addr;
   } vec_t;

   vec_t vec [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc(input logic st, input logic [31:0] d, input logic rq);
      @(negedge clk);
      store = st; din = d; load_req = rq;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; store = 1'b0; load_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_grant"},   32'(load_grant),  32'd0);
      chk({tag, "_dout"},    dout,             32'd0);
      chk({tag, "_delayed"}, 32'(trg_delayed), 32'd0);
      chk({tag, "_addr"},    32'(trg_addr),    32'd0);
      chk({tag, "_perm"},    32'(store_perm),  32'd1);
   endtask

   initial begin
      logic [31:0] q[$];
      logic        pending;
      logic        prev_gnt;
      logic        do_load;
      logic        st_r;
      logic [31:0] d_r;
      logic [31:0] exp_d;
      logic [31:0] last_d;

      //         st    d       rq    ev    perm  gnt   dout    dly   addr
      vec[0]  = '{1'b1, 32'd1,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0};
      vec[1]  = '{1'b1, 32'd2,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0};
      vec[2]  = '{1'b1, 32'd3,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0};
      vec[3]  = '{1'b1, 32'd4,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0};
      vec[4]  = '{1'b1, 32'd5,  1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0};
      vec[5]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 2'd0};
      vec[6]  = '{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0, 2'd0};
      vec[7]  = '{1'b1, 32'd6,  1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 2'd0};
      vec[8]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0, 2'd0};
      vec[9]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 2'd0};
      vec[10] = '{1'b1, 32'd7,  1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 2'd2};
      vec[11] = '{1'b1, 32'd8,  1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 2'd2};
      vec[12] = '{1'b1, 32'd9,  1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 2'd2};
      vec[13] = '{1'b1, 32'd10, 1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 2'd2};
      vec[14] = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'd3, 1'b1, 2'd2};
      vec[15] = '{1'b1, 32'd11, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 2'd2};
      vec[16] = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 1'b1, 2'd2};

      #2 rst_n = 1'b0;
      #1 chk_reset_outs("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Trace mode: delay line, same-cycle read-before-write, trigger capture and freeze.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         store = vec[i].st; din = vec[i].d; load_req = vec[i].rq; trg_event = vec[i].ev;
         #1 chk($sformatf("v%0d_perm", i), 32'(store_perm), 32'(vec[i].exp_perm));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_grant", i),   32'(load_grant),  32'(vec[i].exp_gnt));
         chk($sformatf("v%0d_dout", i),    dout,             vec[i].exp_dout);
         chk($sformatf("v%0d_delayed", i), 32'(trg_delayed), 32'(vec[i].exp_dly));
         chk($sformatf("v%0d_addr", i),    32'(trg_addr),    32'(vec[i].exp_addr));
      end

      // Asynchronous reset while DELAYING with a grant outstanding.
      trg_event = 1'b0;
      do_reset();
      cyc(1'b1, 32'd1, 1'b0);
      cyc(1'b1, 32'd2, 1'b0);
      trg_event = 1'b1;
      cyc(1'b0, 32'd0, 1'b0);
      chk("rst_pre_addr", 32'(trg_addr), 32'd2);
      cyc(1'b1, 32'd3, 1'b1);
      chk("rst_pre_grant", 32'(load_grant), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("midrst");
      trg_event = 1'b0; store = 1'b0; load_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("midrst_no_grant", 32'(load_grant), 32'd0);

      // Zero delay: freeze the cycle after entry; a store while frozen must not land.
      trg_delay = 16'd0;
      do_reset();
      for (int i = 1; i <= D; i++) cyc(1'b1, 32'(i), 1'b0);
      trg_event = 1'b1;
      cyc(1'b0, 32'd0, 1'b0);
      chk("z_entry_delayed", 32'(trg_delayed), 32'd0);
      cyc(1'b0, 32'd0, 1'b0);
      chk("z_frozen_delayed", 32'(trg_delayed), 32'd1);
      chk("z_frozen_perm",    32'(store_perm),  32'd0);
      cyc(1'b1, 32'd99, 1'b0);
      cyc(1'b0, 32'd0, 1'b1);
      chk("z_frozen_grant", 32'(load_grant), 32'd1);
      chk("z_frozen_dout",  dout,            32'd1);

      // Leaving a frozen trace buffer by switching to stream mode.
      load_req = 1'b0;
      mode = 2'd1;
      cyc(1'b0, 32'd0, 1'b0);
      trg_event = 1'b0;
      chk("m1_delayed", 32'(trg_delayed), 32'd0);
      chk("m1_perm",    32'(store_perm),  32'd1);
      chk("m1_grant",   32'(load_grant),  32'd0);

      // Stream: fill, full refuses even alongside a load, wrap order.
      for (int i = 0; i < D; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0);
      chk("s_full_perm", 32'(store_perm), 32'd0);
      cyc(1'b1, 32'hEE, 1'b1);
      chk("s_first_grant", 32'(load_grant), 32'd1);
      chk("s_first_dout",  dout,            32'hA0);
      chk("s_after_perm",  32'(store_perm), 32'd1);
      cyc(1'b1, 32'hA0 + 32'(D), 1'b0);
      chk("s_refull_perm", 32'(store_perm), 32'd0);
      for (int i = 1; i <= D; i++) begin
         cyc(1'b0, 32'd0, 1'b1);
         chk($sformatf("s_drain%0d_grant", i), 32'(load_grant), 32'd1);
         chk($sformatf("s_drain%0d_dout", i),  dout,            32'hA0 + 32'(i));
         cyc(1'b0, 32'd0, 1'b0);
      end

      // Stream empty: request stays pending, then one store is granted two cycles later.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 32'd0, 1'b1);
         chk($sformatf("e%0d_grant", i), 32'(load_grant), 32'd0);
      end
      chk("e_hold_dout", dout, 32'hA0 + 32'(D));
      cyc(1'b1, 32'h55, 1'b1);
      chk("e_store_grant", 32'(load_grant), 32'd0);
      cyc(1'b0, 32'd0, 1'b1);
      chk("e_late_grant", 32'(load_grant), 32'd1);
      chk("e_late_dout",  dout,            32'h55);

      // Mode toggle mid-stream discards the queued words and realigns pointers.
      cyc(1'b1, 32'h11, 1'b0);
      cyc(1'b1, 32'h22, 1'b0);
      mode = 2'd2;
      cyc(1'b0, 32'd0, 1'b0);
      chk("m2_perm",    32'(store_perm),  32'd1);
      chk("m2_grant",   32'(load_grant),  32'd0);
      chk("m2_delayed", 32'(trg_delayed), 32'd0);
      cyc(1'b0, 32'd0, 1'b1);
      chk("m2_empty_grant", 32'(load_grant), 32'd0);
      cyc(1'b1, 32'h33, 1'b1);
      cyc(1'b0, 32'd0, 1'b1);
      chk("m2_ptr_grant", 32'(load_grant), 32'd1);
      chk("m2_ptr_dout",  dout,            32'h33);
      cyc(1'b0, 32'd0, 1'b0);

      // Random stream traffic against a queue model of the FIFO.
      pending = 1'b0; prev_gnt = 1'b0; last_d = 32'h33;
      for (int n = 0; n < 600; n++) begin
         st_r = ($urandom % 3) != 0;
         d_r  = $urandom;
         if (!pending && ($urandom % 2) == 1) pending = 1'b1;
         @(negedge clk);
         store = st_r; din = d_r; load_req = pending;
         #1 chk("r_perm", 32'(store_perm), 32'(q.size() < D));
         do_load = pending && !prev_gnt && (q.size() > 0);
         if (st_r && q.size() < D) begin
            if (do_load) begin
               exp_d = q.pop_front();
               last_d = exp_d;
            end
            q.push_back(d_r);
         end else if (do_load) begin
            exp_d = q.pop_front();
            last_d = exp_d;
         end
         @(posedge clk);
         #1;
         chk("r_grant", 32'(load_grant), 32'(do_load));
         chk("r_dout",  dout,            last_d);
         prev_gnt = do_load;
         if (do_load) pending = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
